// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 timing generator: default porch/sync
// timings, total-count derivations, the 10-bit coordinate type and the test-bar palette.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF = span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic   pix_req;
    logic   hs;
    logic   vs;
    coord_t h;
    coord_t v;
  } stage1_t;

  localparam int unsigned BAR_WIDTH = 80;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input coord_t col);
    coord_t idx;
    idx = col / coord_t'(BAR_WIDTH);
    case (idx)
      10'd0:   return RGB_WHITE;
      10'd1:   return RGB_YELLOW;
      10'd2:   return RGB_CYAN;
      10'd3:   return RGB_GREEN;
      10'd4:   return RGB_MAGENTA;
      10'd5:   return RGB_RED;
      10'd6:   return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_lock_sync.sv
// Two-flop synchronizer bringing the PLL lock indication into the pixel clock domain.
module vga_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], async_i};
    end
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 pixel-timing generator: counters, then two register stages so pix_req leads de.
// Optional VGA_TIMING_TESTPAT_EN adds a registered 8-bar colour pattern on test_rgb.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  input  logic        enable,
  output logic        pix_req,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_TIMING_TESTPAT_EN
  ,
  output logic [23:0] test_rgb
`endif
);

  localparam coord_t H_LAST   = coord_t'(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam coord_t V_LAST   = coord_t'(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  logic    locked_s;
  logic    run;
  coord_t  h_cnt_q, h_cnt_d;
  coord_t  v_cnt_q, v_cnt_d;
  stage1_t s1_q, s1_d;
  logic    de_q, hsync_q, vsync_q, line_start_q, frame_start_q;
  coord_t  x_q, y_q;

  vga_lock_sync u_lock_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (pll_locked),
    .sync_o  (locked_s)
  );

  assign run = locked_s & enable;

  // Dropping run clears the counters at once, so every restart begins at the frame origin.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

  always_comb begin
    s1_d = '0;
    if (run) begin
      s1_d.pix_req = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      s1_d.hs      = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
      s1_d.vs      = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
      s1_d.h       = h_cnt_q;
      s1_d.v       = v_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      s1_q    <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      s1_q    <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q          <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      de_q          <= s1_q.pix_req;
      hsync_q       <= s1_q.hs ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= s1_q.vs ? SYNC_POL : ~SYNC_POL;
      x_q           <= s1_q.h;
      y_q           <= s1_q.v;
      line_start_q  <= s1_q.pix_req && (s1_q.h == '0);
      frame_start_q <= s1_q.pix_req && (s1_q.h == '0) && (s1_q.v == '0);
    end
  end

`ifdef VGA_TIMING_TESTPAT_EN
  logic [23:0] test_rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_rgb_q <= '0;
    end else begin
      test_rgb_q <= s1_q.pix_req ? bar_color(s1_q.h) : 24'h000000;
    end
  end

  assign test_rgb = test_rgb_q;
`endif

  assign pix_req     = s1_q.pix_req;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full horizontal timing with a shortened vertical frame,
// position-based reference model checked every cycle plus hand-computed timing checks.
module tb_vga_timing_gen;

  localparam int H_A = 640, H_F = 16, H_S = 96, H_B = 48;
  localparam int V_A = 4, V_F = 2, V_S = 2, V_B = 2;
  localparam int HT = H_A + H_F + H_S + H_B;
  localparam int VT = V_A + V_F + V_S + V_B;
  localparam int FRAME = HT * VT;
  localparam bit SP = 1'b0;

  logic clk = 1'b0;
  bit   clk_run = 1'b1;
  logic rst_n, pll_locked, enable;
  logic pix_req, de, hsync, vsync, line_start, frame_start;
  logic [9:0] x, y;
`ifdef VGA_TIMING_TESTPAT_EN
  logic [23:0] test_rgb;
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 if (clk_run) clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B), .SYNC_POL(SP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .enable      (enable),
    .pix_req     (pix_req),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VGA_TIMING_TESTPAT_EN
    ,
    .test_rgb    (test_rgb)
`endif
  );

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Reference model: track the raster position since run last rose (-1 = idle).
  // pos1 drives the pix_req expectation, pos2 (one clock older) the de-aligned outputs.
  logic hist1, hist2;
  int   streak, pos1, pos2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1 <= 1'b0; hist2 <= 1'b0; streak <= 0; pos1 <= -1; pos2 <= -1;
    end else begin
      hist1 <= pll_locked;
      hist2 <= hist1;
      pos2  <= pos1;
      if (hist2 && enable) begin
        pos1   <= streak % FRAME;
        streak <= streak + 1;
      end else begin
        pos1   <= -1;
        streak <= 0;
      end
    end
  end

  function automatic bit act(input int p);
    return p >= 0 && (p % HT) < H_A && (p / HT) < V_A;
  endfunction
  function automatic bit hs_on(input int p);
    return p >= 0 && (p % HT) >= H_A + H_F && (p % HT) < H_A + H_F + H_S;
  endfunction
  function automatic bit vs_on(input int p);
    return p >= 0 && (p / HT) >= V_A + V_F && (p / HT) < V_A + V_F + V_S;
  endfunction

  bit m_ok, m_de;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      m_de = act(pos2);
      m_ok = (pix_req === act(pos1)) && (de === m_de)
          && (hsync === (hs_on(pos2) ? SP : ~SP)) && (vsync === (vs_on(pos2) ? SP : ~SP))
          && (line_start === (m_de && (pos2 % HT) == 0)) && (frame_start === (m_de && pos2 == 0));
      if (pos2 < 0) m_ok = m_ok && x == 10'd0 && y == 10'd0;
      else if (m_de) m_ok = m_ok && int'(x) == pos2 % HT && int'(y) == pos2 / HT;
`ifdef VGA_TIMING_TESTPAT_EN
      m_ok = m_ok && (test_rgb === (m_de ? bar_tab[(pos2 % HT) / 80] : 24'h0));
`endif
      check(m_ok, "model",
            $sformatf("t=%0t got pix_req=%b de=%b hs=%b vs=%b x=%0d y=%0d ls=%b fs=%b; want pix_req=%b de=%b pos=%0d",
                      $time, pix_req, de, hsync, vsync, x, y, line_start, frame_start,
                      act(pos1), m_de, pos2));
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0: return de;
      1: return hsync;
      2: return vsync;
      default: return frame_start;
    endcase
  endfunction

  function automatic bit is_idle();
    return !de && !pix_req && !line_start && !frame_start && x == 10'd0 && y == 10'd0
        && hsync == ~SP && vsync == ~SP;
  endfunction

  task automatic count_while(input int sel, input logic lvl, input int limit, output int n);
    n = 0;
    while (sig(sel) === lvl && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_pos(input int px, input int py, input int limit, input string name);
    int k = 0;
    while (!(de === 1'b1 && int'(x) == px && int'(y) == py) && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) check(1'b0, name, $sformatf("timeout waiting for x=%0d y=%0d", px, py));
  endtask

  task automatic wait_frame_start(input int limit, output int k);
    k = 0;
    while (frame_start !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n, ls, k;

  initial begin
    rst_n = 1'b0; pll_locked = 1'b1; enable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check(is_idle() && hsync === 1'b1 && vsync === 1'b1, "reset_idle",
            $sformatf("got de=%b hs=%b vs=%b x=%0d y=%0d, want idle with syncs high", de, hsync, vsync, x, y));
    end
    pll_locked = 1'b0;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    $display("phase: lock and startup latency");
    pll_locked = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check(pix_req === 1'b0, "pixreq_edge2", $sformatf("got %b want 0", pix_req));
    @(posedge clk); #1;
    check(pix_req === 1'b1 && de === 1'b0, "pixreq_edge3", $sformatf("got pix_req=%b de=%b want 1/0", pix_req, de));
    @(posedge clk); #1;
    check(de === 1'b1 && frame_start === 1'b1 && x == 10'd0 && y == 10'd0, "de_edge4",
          $sformatf("got de=%b fs=%b x=%0d y=%0d want 1/1/0/0", de, frame_start, x, y));
    @(negedge clk);

    $display("phase: line and frame timing");
    count_while(0, 1'b1, 2000, n);
    check(n == 640, "de_high_len", $sformatf("got %0d want 640", n));
    count_while(0, 1'b0, 2000, n);
    check(n == 160, "de_low_len", $sformatf("got %0d want 160", n));
    count_while(1, 1'b1, 2000, n);
    check(n == 656, "hsync_offset", $sformatf("got %0d want 656", n));
    count_while(1, 1'b0, 2000, n);
    check(n == 96, "hsync_width", $sformatf("got %0d want 96", n));
    wait_frame_start(20000, k);
    count_while(2, 1'b1, 20000, n);
    check(n == 4800, "vsync_offset", $sformatf("got %0d want 4800", n));
    count_while(2, 1'b0, 20000, n);
    check(n == 1600, "vsync_width", $sformatf("got %0d want 1600", n));
    wait_frame_start(20000, k);
    n = 0; ls = 0;
    do begin
      if (line_start === 1'b1) ls++;
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 20000);
    check(n == 8000, "frame_period", $sformatf("got %0d want 8000", n));
    check(ls == 4, "line_starts", $sformatf("got %0d want 4", ls));

    $display("phase: lock loss mid-frame");
    wait_pos(300, 2, 20000, "wait_lock_drop");
    pll_locked = 1'b0;
    k = 0;
    while (!is_idle() && k < 10) begin @(negedge clk); k++; end
    check(k >= 1 && k <= 4, "lock_drop_idle", $sformatf("got %0d clocks want 1..4", k));
    repeat (20) @(negedge clk);
    pll_locked = 1'b1;
    wait_frame_start(10, k);
    check(k == 4 && x == 10'd0 && y == 10'd0, "relock_restart",
          $sformatf("got k=%0d x=%0d y=%0d want 4/0/0", k, x, y));

    $display("phase: enable drop mid-frame");
    wait_pos(5, 1, 20000, "wait_en_drop");
    enable = 1'b0;
    k = 0;
    while (!is_idle() && k < 10) begin @(negedge clk); k++; end
    check(k == 2, "enable_drop_idle", $sformatf("got %0d clocks want 2", k));
    repeat (7) @(negedge clk);
    enable = 1'b1;
    wait_frame_start(10, k);
    check(k == 2 && x == 10'd0 && y == 10'd0, "reenable_restart",
          $sformatf("got k=%0d x=%0d y=%0d want 2/0/0", k, x, y));

`ifdef VGA_TIMING_TESTPAT_EN
    $display("phase: test pattern bars");
    wait_pos(79, 0, 20000, "wait_x79");
    check(test_rgb === 24'hFFFFFF, "rgb_x79", $sformatf("got %h want FFFFFF", test_rgb));
    @(negedge clk);
    check(test_rgb === 24'hFFFF00, "rgb_x80", $sformatf("got %h want FFFF00", test_rgb));
    wait_pos(639, 0, 20000, "wait_x639");
    check(test_rgb === 24'h000000, "rgb_x639", $sformatf("got %h want 000000", test_rgb));
    @(negedge clk);
    check(de === 1'b0 && test_rgb === 24'h000000, "rgb_blank", $sformatf("got de=%b rgb=%h want 0/0", de, test_rgb));
`endif

    $display("phase: async reset with clock stopped");
    wait_pos(100, 1, 20000, "wait_async_rst");
    chk_en = 1'b0;
    clk_run = 1'b0;
    #20;
    rst_n = 1'b0;
    #3;
    check(is_idle(), "async_reset_idle",
          $sformatf("got de=%b pix_req=%b hs=%b vs=%b x=%0d y=%0d want idle", de, pix_req, hsync, vsync, x, y));
    #10;
    rst_n = 1'b1;
    clk_run = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    $display("phase: randomized enable/lock activity");
    repeat (16000) begin
      @(negedge clk);
      k = int'($urandom_range(0, 1499));
      if (k == 0) enable = ~enable;
      else if (k == 1) pll_locked = ~pll_locked;
      else if (k < 6 && !(enable && pll_locked)) begin
        enable = 1'b1;
        pll_locked = 1'b1;
      end
    end
    enable = 1'b1;
    pll_locked = 1'b1;
    repeat (50) @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
